// File: rtl/cu_control_buffer_pipe_pkg.sv
// Shared control-unit definitions: microword field layout, sequencer state encoding and width
// derivation. Reused by the control store, sequencer and control buffer register.
package cu_control_buffer_pipe_pkg;

  localparam int unsigned DefNCtrl     = 16;
  localparam int unsigned DefAluOpW    = 4;
  localparam int unsigned DefNextW     = 2;
  localparam int unsigned DefStallCntW = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } cu_state_e;

  // Microword layout, LSB first: C bits, ALU op, next_addr, mar_inc, halt (MSB).
  function automatic int unsigned cw_width(input int unsigned n_ctrl, input int unsigned alu_op_w,
                                           input int unsigned next_w);
    return n_ctrl + alu_op_w + next_w + 2;
  endfunction

  function automatic int unsigned alu_lsb(input int unsigned n_ctrl);
    return n_ctrl;
  endfunction

  function automatic int unsigned next_lsb(input int unsigned n_ctrl, input int unsigned alu_op_w);
    return n_ctrl + alu_op_w;
  endfunction

  function automatic int unsigned mar_inc_bit(input int unsigned n_ctrl,
                                              input int unsigned alu_op_w,
                                              input int unsigned next_w);
    return n_ctrl + alu_op_w + next_w;
  endfunction

  function automatic int unsigned halt_bit(input int unsigned n_ctrl, input int unsigned alu_op_w,
                                           input int unsigned next_w);
    return n_ctrl + alu_op_w + next_w + 1;
  endfunction

endpackage

// File: rtl/cu_control_buffer_pipe_if.sv
// Control-memory / datapath signal bundle for the control buffer register.
// master = control side driving the buffer, slave = the buffer itself.
interface cu_control_buffer_pipe_if #(
  parameter int unsigned N_CTRL      = cu_control_buffer_pipe_pkg::DefNCtrl,
  parameter int unsigned ALU_OP_W    = cu_control_buffer_pipe_pkg::DefAluOpW,
  parameter int unsigned NEXT_W      = cu_control_buffer_pipe_pkg::DefNextW,
  parameter int unsigned STALL_CNT_W = cu_control_buffer_pipe_pkg::DefStallCntW,
  parameter int unsigned CW_WIDTH    = cu_control_buffer_pipe_pkg::cw_width(N_CTRL, ALU_OP_W,
                                                                            NEXT_W)
);
  logic                   ctrl_cpu_start;
  logic [CW_WIDTH-1:0]    mem_word;
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   cu_ready;
  logic                   ctrl_flush;
  logic                   halt_clear;
  logic                   cbr_valid;
  logic [N_CTRL-1:0]      ctrl_bus;
  logic [ALU_OP_W-1:0]    ALU_op;
  logic [NEXT_W-1:0]      next_addr;
  logic                   ctrl_mar_increment;
  logic                   ctrl_global_halt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ctrl_cpu_start, mem_word, mem_valid, cu_ready, ctrl_flush, halt_clear,
    input  mem_ready, cbr_valid, ctrl_bus, ALU_op, next_addr, ctrl_mar_increment,
           ctrl_global_halt, stall_cnt
  );

  modport slave (
    input  ctrl_cpu_start, mem_word, mem_valid, cu_ready, ctrl_flush, halt_clear,
    output mem_ready, cbr_valid, ctrl_bus, ALU_op, next_addr, ctrl_mar_increment,
           ctrl_global_halt, stall_cnt
  );
endinterface

// File: rtl/cu_cbr_skid_buf.sv
// Two-entry valid/ready skid buffer: OUT drives the consumer, SKID catches a word accepted while
// OUT is stalled. Synchronous clear empties both entries and overrides any accept.
module cu_cbr_skid_buf #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             skid_valid_o,
  output logic [WIDTH-1:0] skid_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept, consume;

  assign in_ready_o   = ~skid_valid_q;
  assign accept       = in_valid_i & ~skid_valid_q;
  assign consume      = out_valid_q & out_ready_i;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign skid_valid_o = skid_valid_q;
  assign skid_data_o  = skid_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (clr_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      // OUT frees up: the older SKID word goes first; accept is blocked while SKID is full.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/cu_control_buffer_pipe.sv
// Control buffer register: buffers microwords from control memory, decodes and gates the fields
// onto the datapath, and sequences start/halt with flush and a saturating stall counter.
module cu_control_buffer_pipe
  import cu_control_buffer_pipe_pkg::*;
#(
  parameter int unsigned N_CTRL      = DefNCtrl,
  parameter int unsigned ALU_OP_W    = DefAluOpW,
  parameter int unsigned NEXT_W      = DefNextW,
  parameter int unsigned CW_WIDTH    = cw_width(N_CTRL, ALU_OP_W, NEXT_W),
  parameter int unsigned STALL_CNT_W = DefStallCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  cu_control_buffer_pipe_if.slave bus
);

  if (CW_WIDTH != cw_width(N_CTRL, ALU_OP_W, NEXT_W)) begin : g_cw_width_check
    $error("CW_WIDTH must equal N_CTRL + ALU_OP_W + NEXT_W + 2");
  end

  localparam int unsigned AluLsb    = alu_lsb(N_CTRL);
  localparam int unsigned NextLsb   = next_lsb(N_CTRL, ALU_OP_W);
  localparam int unsigned MarIncBit = mar_inc_bit(N_CTRL, ALU_OP_W, NEXT_W);
  localparam int unsigned HaltBit   = halt_bit(N_CTRL, ALU_OP_W, NEXT_W);
  localparam logic [CW_WIDTH-1:0] HaltMask = CW_WIDTH'(1) << HaltBit;

  cu_state_e              state_q, state_d;
  logic                   buf_clr, buf_in_valid, buf_in_ready;
  logic                   out_valid, skid_valid;
  logic [CW_WIDTH-1:0]    out_word, skid_word;
  logic                   out_halt, skid_halt, consume, mem_ready;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign out_halt  = out_valid & |(out_word & HaltMask);
  assign skid_halt = skid_valid & |(skid_word & HaltMask);
  assign consume   = out_valid & bus.cu_ready;

  cu_cbr_skid_buf #(
    .WIDTH (CW_WIDTH)
  ) u_skid_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (buf_clr),
    .in_valid_i   (buf_in_valid),
    .in_ready_o   (buf_in_ready),
    .in_data_i    (bus.mem_word),
    .out_valid_o  (out_valid),
    .out_data_o   (out_word),
    .out_ready_i  (bus.cu_ready),
    .skid_valid_o (skid_valid),
    .skid_data_o  (skid_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.ctrl_cpu_start) state_d = StRun;
      StRun: begin
        if (!bus.ctrl_cpu_start)      state_d = StIdle;
        else if (consume && out_halt) state_d = StHalted;
      end
      StHalted: if (bus.halt_clear)   state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Fetch stops once a halt word is buffered so nothing past it is ever taken.
  always_comb begin
    mem_ready = (state_q == StRun) & buf_in_ready & ~bus.ctrl_flush & ~out_halt & ~skid_halt;
    buf_clr   = (state_q == StRun) & (~bus.ctrl_cpu_start | bus.ctrl_flush);
    bus.ctrl_global_halt = (state_q == StHalted) | out_halt;
  end

  assign buf_in_valid   = bus.mem_valid & mem_ready;
  assign bus.mem_ready  = mem_ready;
  assign bus.cbr_valid  = out_valid;

  assign bus.ctrl_bus           = out_word[N_CTRL-1:0] & {N_CTRL{out_valid}};
  assign bus.ALU_op             = out_word[AluLsb +: ALU_OP_W] & {ALU_OP_W{out_valid}};
  assign bus.next_addr          = out_word[NextLsb +: NEXT_W] & {NEXT_W{out_valid}};
  assign bus.ctrl_mar_increment = out_word[MarIncBit] & out_valid;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.cu_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_cu_control_buffer_pipe.sv
// Directed bench for the control buffer register: streaming, skid/stall, halt, flush,
// start drop, reset mid-stall and stall counter saturation on a narrow-counter instance.
module tb_cu_control_buffer_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cu_control_buffer_pipe_if bus ();
  cu_control_buffer_pipe_if #(.STALL_CNT_W(3)) bus3 ();

  cu_control_buffer_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cu_control_buffer_pipe #(
    .STALL_CNT_W (3)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mk_word(input logic h, input logic m, input logic [1:0] n,
                                          input logic [3:0] a, input logic [15:0] c);
    return {h, m, n, a, c};
  endfunction

  // One rising edge, then park on the falling edge to sample and drive.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ctrl_cpu_start = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_word = 24'hFFFFFF;
    bus.cu_ready = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL reset_mem_ready: got %b want 0", bus.mem_ready); end
    checks++; if (bus.cbr_valid !== 1'b0) begin failures++;
      $display("FAIL reset_cbr_valid: got %b want 0", bus.cbr_valid); end
    checks++; if (bus.ctrl_bus !== 16'h0000) begin failures++;
      $display("FAIL reset_ctrl_bus: got %h want 0000", bus.ctrl_bus); end
    checks++; if ({bus.ALU_op, bus.next_addr, bus.ctrl_mar_increment} !== 7'd0) begin failures++;
      $display("FAIL reset_fields: got %h %h %b want 0 0 0", bus.ALU_op, bus.next_addr,
               bus.ctrl_mar_increment); end
    checks++; if (bus.ctrl_global_halt !== 1'b0) begin failures++;
      $display("FAIL reset_halt: got %b want 0", bus.ctrl_global_halt); end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++;
      $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    rst = 1'b0;
    bus.ctrl_cpu_start = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_word = '0;
    cyc();
    checks++; if (bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL idle_mem_ready: got %b want 0", bus.mem_ready); end
  endtask

  task automatic test_stream();
    logic [15:0] c [3];
    logic [3:0]  a [3];
    logic [1:0]  n [3];
    logic        m [3];
    logic [23:0] w [3];
    c = '{16'h0001, 16'h0002, 16'h0004};
    a = '{4'h3, 4'h5, 4'hA};
    n = '{2'd1, 2'd2, 2'd3};
    m = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) w[i] = mk_word(1'b0, m[i], n[i], a[i], c[i]);
    bus.ctrl_cpu_start = 1'b1;
    bus.cu_ready = 1'b1;
    cyc();
    checks++; if (bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL run_mem_ready: got %b want 1", bus.mem_ready); end
    bus.mem_valid = 1'b1;
    bus.mem_word = w[0];
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.cbr_valid !== 1'b1 || bus.ctrl_bus !== c[i]) begin failures++;
        $display("FAIL stream_word[%0d]: got v=%b C=%h want v=1 C=%h", i, bus.cbr_valid,
                 bus.ctrl_bus, c[i]); end
      checks++; if (bus.ALU_op !== a[i] || bus.next_addr !== n[i]
                    || bus.ctrl_mar_increment !== m[i]) begin failures++;
        $display("FAIL stream_fields[%0d]: got %h %h %b want %h %h %b", i, bus.ALU_op,
                 bus.next_addr, bus.ctrl_mar_increment, a[i], n[i], m[i]); end
      checks++; if (bus.mem_ready !== 1'b1) begin failures++;
        $display("FAIL stream_mem_ready[%0d]: got %b want 1", i, bus.mem_ready); end
      if (i < 2) bus.mem_word = w[i+1];
      else bus.mem_valid = 1'b0;
    end
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.ctrl_bus !== 16'h0000) begin failures++;
      $display("FAIL stream_drain: got v=%b C=%h want v=0 C=0000", bus.cbr_valid,
               bus.ctrl_bus); end
    checks++; if (bus.stall_cnt !== 16'd0) begin failures++;
      $display("FAIL stream_stall_cnt: got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_stall();
    bus.cu_ready = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0100);
    cyc();
    checks++; if (bus.ctrl_bus !== 16'h0100 || bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL stall_first: got C=%h rdy=%b want C=0100 rdy=1", bus.ctrl_bus,
               bus.mem_ready); end
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0200);
    cyc();
    checks++; if (bus.mem_ready !== 1'b0 || bus.ctrl_bus !== 16'h0100) begin failures++;
      $display("FAIL stall_skid_full: got rdy=%b C=%h want rdy=0 C=0100", bus.mem_ready,
               bus.ctrl_bus); end
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0400);
    repeat (3) cyc();
    checks++; if (bus.stall_cnt !== 16'd4) begin failures++;
      $display("FAIL stall_cnt4: got %0d want 4", bus.stall_cnt); end
    checks++; if (bus.mem_ready !== 1'b0 || bus.ctrl_bus !== 16'h0100) begin failures++;
      $display("FAIL stall_hold: got rdy=%b C=%h want rdy=0 C=0100", bus.mem_ready,
               bus.ctrl_bus); end
    bus.cu_ready = 1'b1;
    cyc();
    checks++; if (bus.ctrl_bus !== 16'h0200 || bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL stall_skid_move: got C=%h rdy=%b want C=0200 rdy=1", bus.ctrl_bus,
               bus.mem_ready); end
    cyc();
    checks++; if (bus.ctrl_bus !== 16'h0400) begin failures++;
      $display("FAIL stall_third: got C=%h want 0400", bus.ctrl_bus); end
    bus.mem_valid = 1'b0;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.stall_cnt !== 16'd4) begin failures++;
      $display("FAIL stall_drain: got v=%b cnt=%0d want v=0 cnt=4", bus.cbr_valid,
               bus.stall_cnt); end
  endtask

  task automatic test_halt();
    bus.cu_ready = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_word = 24'h800010;
    cyc();
    checks++; if (bus.ctrl_global_halt !== 1'b1 || bus.ctrl_bus !== 16'h0010) begin failures++;
      $display("FAIL halt_in_out: got h=%b C=%h want h=1 C=0010", bus.ctrl_global_halt,
               bus.ctrl_bus); end
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0020);
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL halt_no_fetch: got %b want 0", bus.mem_ready); end
    bus.cu_ready = 1'b1;
    cyc();
    checks++; if (bus.mem_ready !== 1'b0 || bus.cbr_valid !== 1'b0 || bus.ctrl_bus !== 16'h0000)
    begin failures++;
      $display("FAIL halted_outputs: got rdy=%b v=%b C=%h want 0 0 0000", bus.mem_ready,
               bus.cbr_valid, bus.ctrl_bus); end
    checks++; if (bus.ctrl_global_halt !== 1'b1 || bus.stall_cnt !== 16'd4) begin failures++;
      $display("FAIL halted_flag: got h=%b cnt=%0d want h=1 cnt=4", bus.ctrl_global_halt,
               bus.stall_cnt); end
    cyc();
    checks++; if (bus.ctrl_global_halt !== 1'b1 || bus.cbr_valid !== 1'b0) begin failures++;
      $display("FAIL halted_sticky: got h=%b v=%b want h=1 v=0", bus.ctrl_global_halt,
               bus.cbr_valid); end
    bus.halt_clear = 1'b1;
    bus.mem_valid = 1'b0;
    cyc();
    checks++; if (bus.ctrl_global_halt !== 1'b0 || bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL halt_clear_idle: got h=%b rdy=%b want 0 0", bus.ctrl_global_halt,
               bus.mem_ready); end
    bus.halt_clear = 1'b0;
    cyc();
    checks++; if (bus.mem_ready !== 1'b1 || bus.cbr_valid !== 1'b0) begin failures++;
      $display("FAIL halt_restart: got rdy=%b v=%b want 1 0", bus.mem_ready, bus.cbr_valid); end
  endtask

  task automatic test_flush();
    bus.cu_ready = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h1000);
    cyc();
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h2000);
    cyc();
    checks++; if (bus.mem_ready !== 1'b0 || bus.ctrl_bus !== 16'h1000
                  || bus.stall_cnt !== 16'd5) begin failures++;
      $display("FAIL flush_full: got rdy=%b C=%h cnt=%0d want 0 1000 5", bus.mem_ready,
               bus.ctrl_bus, bus.stall_cnt); end
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h4000);
    bus.ctrl_flush = 1'b1;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.ctrl_bus !== 16'h0000
                  || bus.stall_cnt !== 16'd6) begin failures++;
      $display("FAIL flush_clear: got v=%b C=%h cnt=%0d want 0 0000 6", bus.cbr_valid,
               bus.ctrl_bus, bus.stall_cnt); end
    bus.ctrl_flush = 1'b0;
    bus.mem_valid = 1'b0;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL flush_skid_gone: got v=%b rdy=%b want 0 1", bus.cbr_valid,
               bus.mem_ready); end
    bus.mem_valid = 1'b1;
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0040);
    bus.ctrl_flush = 1'b1;
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL flush_blocks_ready: got %b want 0", bus.mem_ready); end
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.stall_cnt !== 16'd6) begin failures++;
      $display("FAIL flush_no_accept: got v=%b cnt=%0d want 0 6", bus.cbr_valid,
               bus.stall_cnt); end
    bus.ctrl_flush = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_start_drop();
    bus.cu_ready = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_word = mk_word(1'b0, 1'b1, 2'd1, 4'h9, 16'h0003);
    cyc();
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h000C);
    cyc();
    checks++; if (bus.ctrl_bus !== 16'h0003 || bus.stall_cnt !== 16'd7) begin failures++;
      $display("FAIL drop_before: got C=%h cnt=%0d want 0003 7", bus.ctrl_bus, bus.stall_cnt); end
    bus.ctrl_cpu_start = 1'b0;
    bus.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0030);
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.ctrl_bus !== 16'h0000 || bus.ALU_op !== 4'h0
                  || bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL drop_cleared: got v=%b C=%h alu=%h rdy=%b want 0 0000 0 0", bus.cbr_valid,
               bus.ctrl_bus, bus.ALU_op, bus.mem_ready); end
    checks++; if (bus.stall_cnt !== 16'd8) begin failures++;
      $display("FAIL drop_stall_kept: got %0d want 8", bus.stall_cnt); end
    bus.ctrl_cpu_start = 1'b1;
    bus.mem_valid = 1'b0;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL drop_restart: got v=%b rdy=%b want 0 1", bus.cbr_valid, bus.mem_ready); end
  endtask

  task automatic test_rst_mid_stall();
    bus.cu_ready = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_word = mk_word(1'b0, 1'b1, 2'd2, 4'h7, 16'h00F0);
    cyc();
    bus.mem_valid = 1'b0;
    checks++; if (bus.ALU_op !== 4'h7 || bus.next_addr !== 2'd2
                  || bus.ctrl_mar_increment !== 1'b1) begin failures++;
      $display("FAIL rst_fields: got %h %h %b want 7 2 1", bus.ALU_op, bus.next_addr,
               bus.ctrl_mar_increment); end
    cyc();
    checks++; if (bus.stall_cnt !== 16'd9) begin failures++;
      $display("FAIL rst_stall_before: got %0d want 9", bus.stall_cnt); end
    rst = 1'b1;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.ctrl_bus !== 16'h0000 || bus.ALU_op !== 4'h0
                  || bus.next_addr !== 2'd0 || bus.ctrl_mar_increment !== 1'b0) begin failures++;
      $display("FAIL rst_outputs: got v=%b C=%h %h %h %b want all 0", bus.cbr_valid,
               bus.ctrl_bus, bus.ALU_op, bus.next_addr, bus.ctrl_mar_increment); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.mem_ready !== 1'b0) begin failures++;
      $display("FAIL rst_stall_clear: got cnt=%0d rdy=%b want 0 0", bus.stall_cnt,
               bus.mem_ready); end
    rst = 1'b0;
    cyc();
    checks++; if (bus.cbr_valid !== 1'b0 || bus.mem_ready !== 1'b1) begin failures++;
      $display("FAIL rst_restart: got v=%b rdy=%b want 0 1", bus.cbr_valid, bus.mem_ready); end
  endtask

  task automatic test_saturate();
    bus3.ctrl_cpu_start = 1'b1;
    bus3.cu_ready = 1'b0;
    cyc();
    bus3.mem_valid = 1'b1;
    bus3.mem_word = mk_word(1'b0, 1'b0, 2'd0, 4'h0, 16'h0055);
    cyc();
    bus3.mem_valid = 1'b0;
    checks++; if (bus3.ctrl_bus !== 16'h0055 || bus3.stall_cnt !== 3'd0) begin failures++;
      $display("FAIL sat_load: got C=%h cnt=%0d want 0055 0", bus3.ctrl_bus, bus3.stall_cnt); end
    repeat (6) cyc();
    checks++; if (bus3.stall_cnt !== 3'd6) begin failures++;
      $display("FAIL sat_cnt6: got %0d want 6", bus3.stall_cnt); end
    repeat (4) cyc();
    checks++; if (bus3.stall_cnt !== 3'd7 || bus3.cbr_valid !== 1'b1) begin failures++;
      $display("FAIL sat_cnt7: got cnt=%0d v=%b want 7 1", bus3.stall_cnt, bus3.cbr_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.ctrl_cpu_start = 1'b0;
    bus.mem_word = '0;
    bus.mem_valid = 1'b0;
    bus.cu_ready = 1'b0;
    bus.ctrl_flush = 1'b0;
    bus.halt_clear = 1'b0;
    bus3.ctrl_cpu_start = 1'b0;
    bus3.mem_word = '0;
    bus3.mem_valid = 1'b0;
    bus3.cu_ready = 1'b0;
    bus3.ctrl_flush = 1'b0;
    bus3.halt_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_halt();
    test_flush();
    test_start_drop();
    test_rst_mid_stall();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
